// File: rtl/bch_chien_search_pkg.sv
// Shared GF(2^M) code parameters, beat geometry helpers and alpha-power arithmetic
// for the BCH Chien search slice.
package bch_chien_search_pkg;

  localparam int M         = 4;
  localparam int T         = 2;
  localparam int N         = (1 << M) - 1;
  localparam int K         = 7;
  localparam int DATA_BITS = 7;
  localparam int SKIP      = K - DATA_BITS;
  localparam int DEG_W     = $clog2(T + 1);
  localparam int TOTAL_W   = DEG_W + 1;

  // Low bits of the primitive polynomial x^4 + x + 1
  localparam logic [M-1:0] PRIM_LOW = 4'b0011;

  typedef logic [M-1:0] gf_t;
  typedef enum logic {IDLE, RUN} state_t;

  function automatic int cycles(input int bits);
    return (DATA_BITS + bits - 1) / bits;
  endfunction

  function automatic int beat_w(input int bits);
    return (cycles(bits) > 1) ? $clog2(cycles(bits)) : 1;
  endfunction

  function automatic int exp_mod(input int e);
    return ((e % N) + N) % N;
  endfunction

  function automatic gf_t mul_alpha(input gf_t a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_LOW : '0);
  endfunction

  function automatic gf_t lpow(input int e);
    gf_t r;
    r = gf_t'(1);
    for (int k = 0; k < exp_mod(e); k++) r = mul_alpha(r);
    return r;
  endfunction

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t r;
    r = '0;
    for (int k = M - 1; k >= 0; k--) r = mul_alpha(r) ^ (b[k] ? a : '0);
    return r;
  endfunction

endpackage

// File: rtl/bch_chien_search_term.sv
// One Chien term register bank: loads a scaled coefficient, then steps by a
// constant alpha power on every accepted beat.
module bch_chien_search_term
  import bch_chien_search_pkg::*;
#(
  parameter int STEP = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [M-1:0] load_val,
  output logic [M-1:0] q
);

  localparam gf_t STEP_POW = lpow(STEP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (load) q <= load_val;
    else if (en)   q <= gf_mul(q, STEP_POW);
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates sigma at BITS field points per beat and streams error flags.
// Optional BCH_CHIEN_FAIL_DETECT_EN adds a root-count vs degree fail flag on the last beat.
module bch_chien_search
  import bch_chien_search_pkg::*;
#(
  parameter int BITS      = 1,
  parameter int REG_RATIO = (BITS < 8) ? BITS : 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(T+1)*M-1:0]   sigma,
  input  logic [DEG_W-1:0]     degree,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      err,
  output logic                 first,
  output logic                 last,
  output logic [TOTAL_W-1:0]   err_total
`ifdef BCH_CHIEN_FAIL_DETECT_EN
  ,
  output logic                 fail
`endif
);

  localparam int BANKS  = BITS / REG_RATIO;
  localparam int CYCLES = cycles(BITS);
  localparam int BEAT_W = beat_w(BITS);
  localparam int BASE   = SKIP + N - BITS + 1;

  if (BITS < 1 || BITS > 32 || REG_RATIO < 1 || REG_RATIO > BITS || (BITS % REG_RATIO) != 0) begin : g_bad_cfg
    $error("bch_chien_search: REG_RATIO must divide BITS and lie in 1..BITS");
  end

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [TOTAL_W-1:0]  acc_q;
  logic [TOTAL_W-1:0]  total_now;
  logic [BITS-1:0]     hit;
  logic [M-1:0]        bank_q [T+1][BANKS];
  logic                accept, fire, last_beat;

  assign accept    = in_valid && (state_q == IDLE);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign fire      = out_valid && out_ready;
  assign last_beat = (beat_q == BEAT_W'(CYCLES - 1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (fire && last_beat) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        beat_q <= '0;
        acc_q  <= '0;
      end else if (fire) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        acc_q  <= total_now;
      end
    end
  end

  // Bank r of term i tracks the field point of bit r*REG_RATIO within the beat.
  for (genvar i = 0; i <= T; i++) begin : g_term
    for (genvar r = 0; r < BANKS; r++) begin : g_bank
      localparam gf_t LOAD_POW = lpow(exp_mod(i * (BASE + r * REG_RATIO)));
      logic [M-1:0] load_val;
      assign load_val = gf_mul(sigma[i*M +: M], LOAD_POW);

      bch_chien_search_term #(.STEP(exp_mod(i * BITS))) u_term (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .en       (fire),
        .load_val (load_val),
        .q        (bank_q[i][r])
      );
    end
  end

  // Bits between banks are derived by constant multipliers off the bank outputs.
  for (genvar b = 0; b < BITS; b++) begin : g_bit
    logic [M-1:0] sum;
    always_comb begin
      sum = '0;
      for (int i = 0; i <= T; i++)
        sum ^= gf_mul(bank_q[i][b / REG_RATIO], lpow(i * (b % REG_RATIO)));
    end
    assign hit[b] = (sum == '0) && ((int'(beat_q) * BITS + b) < DATA_BITS);
  end

  always_comb begin
    int sum_total;
    sum_total = int'(acc_q) + $countones(hit);
    total_now = (sum_total > T + 1) ? TOTAL_W'(T + 1) : TOTAL_W'(sum_total);
  end

  assign err       = out_valid ? hit : '0;
  assign first     = out_valid && (beat_q == '0);
  assign last      = out_valid && last_beat;
  assign err_total = out_valid ? total_now : acc_q;

`ifdef BCH_CHIEN_FAIL_DETECT_EN
  logic [DEG_W-1:0] degree_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    degree_q <= '0;
    else if (accept) degree_q <= degree;
  end

  // A saturated count always exceeds any legal degree, so it is flagged too.
  assign fail = last && ((total_now != {1'b0, degree_q}) || (total_now == TOTAL_W'(T + 1)));
`else
  logic unused_degree;
  assign unused_degree = ^degree;
`endif

endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
Next-generation Chien search for the BCH decoder. It takes an error-locator polynomial sigma and its degree from the Berlekamp stage, and evaluates sigma at BITS consecutive field points per beat. It emits per-bit error flags over a valid/ready stream with full output backpressure and first/last framing. The root count is checked against the locator degree to flag uncorrectable blocks. It sits between the key-equation solver and the error-correction XOR stage.

Parameters:
P, `BCH_SANE, packed BCH parameter set (M, T, N, K, DATA_BITS derived via bch_defs.vh macros)
BITS, 1, data bits evaluated per output beat (1..32)
REG_RATIO, min(BITS,8), one real register bank per REG_RATIO bits; other bits derived combinationally; must divide into BITS, must be <= BITS (else elaboration error)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  sigma/degree valid
in_ready  out  1  block idle, sigma accepted on in_valid&&in_ready
sigma  in  (T+1)*M  locator coefficients; sigma[i*M+:M] = coefficient i
degree  in  clog2(T+1)  degree of sigma
out_valid  out  1  err beat valid
out_ready  in  1  downstream accepts beat
err  out  BITS  err[b]=1: data bit beat*BITS+b is in error
first  out  1  qualifies first beat
last  out  1  qualifies final beat
err_total  out  clog2(T+1)+1  running root count, saturating at T+1

Behaviour:
- Reset (async, reset_n=0): in_ready=1, out_valid=0, err=0, first=0, last=0, err_total=0; term registers and beat counter 0; state IDLE.
- States: IDLE -> RUN on accept. RUN -> IDLE on handshake of the last beat. No other transitions.
- Accept (cycle 0): each term register i loads sigma_i * alpha^(i*(SKIP+N-BITS+1)), where SKIP = K-DATA_BITS. degree is latched, beat counter cleared, err_total cleared.
- Cycle 1: out_valid=1, first=1. err[b] = (XOR over i of term_i(b) == 0).
- Advance rule: term registers multiply by alpha^(i*BITS) and the beat counter increments only on out_valid&&out_ready. With out_ready=0, err/first/last/err_total hold stable.
- CYCLES = ceil(DATA_BITS/BITS). last=1 on beat CYCLES-1. first and last are both 1 when CYCLES=1.
- Partial final beat: err bits with index >= DATA_BITS forced 0 and excluded from err_total.
- err_total = roots counted on beats already handshaken plus popcount of the current beat. Saturates at T+1.
- in_ready rises the cycle after the last-beat handshake. A new sigma is accepted no earlier than that, so there is no overlap.
- in_valid while busy: ignored, and sigma is not sampled.
- reset_n asserted mid-block: immediate abort to reset values. No partial beat is emitted after release.
- All-zero sigma: every bit flags error (a degenerate locator). No special casing.

Optional Feature:
BCH_CHIEN_FAIL_DETECT_EN
- Defined: adds output fail (1 bit, reset 0), valid only with the last beat. fail=1 iff err_total on the last beat != latched degree, or the root count saturated. It is cleared on the next accept.
- Undefined: no fail port logic, and degree is ignored (port retained, unused).

Decomposition:
- Shared header bch_chien_pkg.vh: CYCLES, SKIP, BEAT_W (counter width), TOTAL_W.
- Shared header also holds the alpha-exponent helper functions, reusing lpow from bch.vh.
- Sub-module bch_chien_term: one M-bit register with load, enable and constant multiplier by alpha^(i*BITS). It is instantiated (T+1)*(BITS/REG_RATIO) times.
- Intermediate bits use combinational constant multipliers off the bank outputs.
- Popcount and compare logic stays in the top.

Test Plan:
- M=4, T=2, DATA_BITS=7, BITS=1, single error at bit 3 (sigma=1+alpha^e·x), out_ready=1 -> 7 beats, err=1 only on beat 3, first on beat 0, last on beat 6, err_total=1, fail=0.
- Same config, BITS=2, errors at bits 0 and 6 -> 4 beats. Beat 0 err=2'b01; beat 3 err=2'b01 with bit 7 masked. err_total=2.
- Backpressure: out_ready toggled 1,0,0,1 during beat 2 -> err/last held stable while stalled. Beat count still 7. in_ready returns 1 exactly one cycle after the last handshake.
- Decode failure: degree=2 but sigma with a root outside the data range -> err_total=1 at last, fail=1. No define -> no fail port.
- reset_n pulsed low at beat 4 -> out_valid=0 immediately, in_ready=1 after release. A fresh zero-error block (sigma=1) then yields all err=0 and err_total=0.
- in_valid held high during RUN with different sigma -> ignored. Outputs match the first block only.
